// File: rtl/state_sequencer.sv
// rtl/state_sequencer.sv - control-unit timing-state generator with memory stretch and halt/resume.
// Optional retired-instruction counter enabled by STATE_SEQUENCER_RETIRE_COUNT_EN.
module state_sequencer #(
  parameter int MAX_STATE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instruction_end,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_ready,
  input  logic        halt_req,
  input  logic        resume,
  output logic [2:0]  state,
  output logic        halted,
  output logic        seq_error,
  output logic [15:0] retired
);

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_HALT = 1'b1
  } mode_e;

  localparam logic [2:0] MAX_Q = 3'(MAX_STATE);

  mode_e      mode_q, mode_d;
  logic [2:0] state_q, state_d;
  logic       err_q, err_d;
  logic       stall;

  // A halted processor never stalls, so stray memory strobes cannot hold off resume.
  assign stall = (mem_read | mem_write) & ~mem_ready & (mode_q == MODE_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= MODE_RUN;
      state_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    state_d = state_q;
    err_d   = err_q;
    if (mode_q == MODE_HALT) begin
      state_d = 3'd0;
      if (resume) begin
        mode_d = MODE_RUN;
      end
    end else if (stall) begin
      state_d = state_q;
    end else if (instruction_end) begin
      state_d = 3'd0;
      if (halt_req) begin
        mode_d = MODE_HALT;
      end
    end else if (state_q == MAX_Q) begin
      state_d = 3'd0;
      err_d   = 1'b1;
    end else begin
      state_d = state_q + 3'd1;
    end
  end

`ifdef STATE_SEQUENCER_RETIRE_COUNT_EN
  logic [15:0] retired_q, retired_d;
  logic        retire;

  assign retire = (mode_q == MODE_RUN) & ~stall & instruction_end;

  always_comb begin
    retired_d = retired_q;
    if (retire) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= 16'h0000;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`else
  assign retired = 16'h0000;
`endif

  assign state     = state_q;
  assign halted    = (mode_q == MODE_HALT);
  assign seq_error = err_q;

endmodule

// File: tb/tb_state_sequencer.sv
// tb/tb_state_sequencer.sv - randomized self-checking bench for state_sequencer against a rule-level model.
module tb_state_sequencer;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instruction_end = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_ready = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [2:0]  state;
  logic        halted;
  logic        seq_error;
  logic [15:0] retired;

  int checks = 0;
  int failures = 0;

  int          m_state;
  bit          m_halted;
  bit          m_err;
  logic [15:0] m_ret;

  state_sequencer #(.MAX_STATE(MAXS)) dut (
    .clk(clk), .reset(reset), .instruction_end(instruction_end),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
    .halt_req(halt_req), .resume(resume), .state(state), .halted(halted),
    .seq_error(seq_error), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_ret();
`ifdef STATE_SEQUENCER_RETIRE_COUNT_EN
    return m_ret;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_halted = 0; m_err = 0; m_ret = 16'h0000;
  endtask

  // Apply one cycle of inputs, advance the reference model by the sequencing rules, sample after the edge.
  task automatic step(input bit ie, input bit rd, input bit wr, input bit rdy, input bit hr, input bit rs);
    instruction_end = ie; mem_read = rd; mem_write = wr; mem_ready = rdy; halt_req = hr; resume = rs;
    if (m_halted) begin
      m_state = 0;
      if (rs) m_halted = 0;
    end else if ((rd || wr) && !rdy) begin
      m_state = m_state;
    end else if (ie) begin
      m_state = 0;
      m_ret = m_ret + 16'd1;
      if (hr) m_halted = 1;
    end else if (m_state == MAXS) begin
      m_state = 0;
      m_err = 1;
    end else begin
      m_state = m_state + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    instruction_end = 0; mem_read = 0; mem_write = 0; mem_ready = 0; halt_req = 0; resume = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++;
    if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    checks++;
    if (seq_error !== 1'b0) begin failures++; $display("FAIL reset_seq_error got=%0b exp=0", seq_error); end
    checks++;
    if (retired !== 16'h0000) begin failures++; $display("FAIL reset_retired got=%h exp=0000", retired); end
  endtask

  task automatic test_basic();
    int exp_seq[6] = '{1, 2, 0, 1, 2, 0};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step((state == 3'd2), 0, 0, 0, 0, 0);
      checks++;
      if (state !== 3'(exp_seq[i])) begin
        failures++; $display("FAIL basic_state[%0d] got=%0d exp=%0d", i, state, exp_seq[i]);
      end
    end
    checks++;
`ifdef STATE_SEQUENCER_RETIRE_COUNT_EN
    if (retired !== 16'd2) begin failures++; $display("FAIL basic_retired got=%0d exp=2", retired); end
`else
    if (retired !== 16'd0) begin failures++; $display("FAIL basic_retired got=%0d exp=0", retired); end
`endif
  endtask

  task automatic test_stall();
    int exp_seq[4] = '{0, 0, 0, 1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step((i == 1), 1, 0, (i == 3), 0, 0);
      checks++;
      if (state !== 3'(exp_seq[i])) begin
        failures++; $display("FAIL stall_state[%0d] got=%0d exp=%0d", i, state, exp_seq[i]);
      end
    end
    checks++;
    if (retired !== 16'd0) begin failures++; $display("FAIL stall_retired got=%0d exp=0", retired); end
  endtask

  task automatic test_halt_resume();
    apply_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    checks++;
    if ({halted, state} !== {1'b1, 3'd0}) begin
      failures++; $display("FAIL halt_enter halted=%0b state=%0d exp halted=1 state=0", halted, state);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0, 0);
      checks++;
      if ({halted, state} !== {1'b1, 3'd0}) begin
        failures++; $display("FAIL halt_hold[%0d] halted=%0b state=%0d exp halted=1 state=0", i, halted, state);
      end
    end
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if ({halted, state} !== {1'b0, 3'd0}) begin
      failures++; $display("FAIL resume_clear halted=%0b state=%0d exp halted=0 state=0", halted, state);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (state !== 3'd1) begin failures++; $display("FAIL resume_fetch got=%0d exp=1", state); end
  endtask

  task automatic test_overrun();
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      checks++;
      if (state !== 3'(i)) begin failures++; $display("FAIL overrun_run[%0d] got=%0d exp=%0d", i, state, i); end
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if ({seq_error, state} !== {1'b1, 3'd0}) begin
      failures++; $display("FAIL overrun_err seq_error=%0b state=%0d exp 1/0", seq_error, state);
    end
    for (int i = 0; i < 4; i++) step((state == 3'd1), 0, 0, 0, 0, 0);
    checks++;
    if (seq_error !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%0b exp=1", seq_error); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if ({halted, state} !== {1'b0, 3'd3}) begin
      failures++; $display("FAIL resume_ignored halted=%0b state=%0d exp 0/3", halted, state);
    end
    resume = 0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({state, halted, seq_error, retired} !== 21'd0) begin
      failures++; $display("FAIL async_reset state=%0d halted=%0b err=%0b retired=%h exp all 0",
                           state, halted, seq_error, retired);
    end
    #1 reset = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (state !== 3'd1) begin failures++; $display("FAIL post_reset_state got=%0d exp=1", state); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 1) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      checks++;
      if ({state, halted, seq_error, retired} !== {3'(m_state), m_halted, m_err, exp_ret()}) begin
        failures++;
        $display("FAIL random[%0d] got state=%0d halted=%0b err=%0b ret=%h exp state=%0d halted=%0b err=%0b ret=%h",
                 i, state, halted, seq_error, retired, m_state, m_halted, m_err, exp_ret());
      end
    end
  endtask

  task automatic test_retire();
    apply_reset();
`ifdef STATE_SEQUENCER_RETIRE_COUNT_EN
    for (int i = 0; i < 65535; i++) step(1, 0, 0, 0, 0, 0);
    checks++;
    if (retired !== 16'hFFFF) begin failures++; $display("FAIL retire_preload got=%h exp=ffff", retired); end
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (retired !== 16'h0000) begin failures++; $display("FAIL retire_wrap got=%h exp=0000", retired); end
`else
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (retired !== 16'h0000) begin failures++; $display("FAIL retire_tied[%0d] got=%h exp=0000", i, retired); end
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_stall();
    test_halt_resume();
    test_overrun();
    test_async_reset();
    test_random();
    test_retire();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
